// File: rtl/mips_pkg.sv
// Shared MIPS constants and the fetch FSM state type for the instruction-side blocks.
package mips_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: synchronous write, combinational read, contents survive reset.
module instr_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter + fetch FSM streaming one registered instruction per cycle to execute_unit.
// Word at pc in cycle N appears on instr after the next edge; stall freezes everything, redirect squashes one slot.
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = mips_pkg::HALT_WORD,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [31:0]   instr_pc,
  output logic [31:0]   pc,
  output logic          halted,
  output logic          fault
);

  import mips_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_fault;

  logic [31:0] w_rd_data;
  logic        w_mem_we;
  logic        w_run;
  logic        w_redirect;
  logic        w_redirect_bad;
  logic        w_fetch;
  logic        w_pc_oor;
  logic        w_fetch_fault;
  logic        w_fetch_halt;

  instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .i_clk   (CLK),
    .i_we    (w_mem_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc[AW+1:2]),
    .o_rdata (w_rd_data)
  );

  // Range checks use the full address so a pc past the array never aliases back into it.
  assign w_run          = (r_state == RUN);
  assign w_redirect     = w_run && redirect_valid;
  assign w_redirect_bad = (redirect_pc[1:0] != 2'b00) || ((redirect_pc >> 2) >= 32'(IMEM_DEPTH));
  assign w_fetch        = w_run && !redirect_valid && !stall;
  assign w_pc_oor       = (r_pc >> 2) >= 32'(IMEM_DEPTH);
  assign w_fetch_fault  = w_fetch && w_pc_oor;
  assign w_fetch_halt   = w_fetch && !w_pc_oor && (w_rd_data == HALT_WORD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_redirect) begin
          if (w_redirect_bad) w_state_nxt = HALTED;
        end else if (w_fetch_fault || w_fetch_halt) begin
          w_state_nxt = HALTED;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    halted   = (r_state == HALTED);
    w_mem_we = (r_state == IDLE) && load_en;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc          <= RESET_PC;
      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= 32'h0;
      r_fault       <= 1'b0;
    end else if (w_redirect) begin
      r_pc          <= redirect_pc;
      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      if (w_redirect_bad) r_fault <= 1'b1;
    end else if (w_fetch_fault || w_fetch_halt) begin
      r_instr       <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_fault       <= w_fetch_fault;
    end else if (w_fetch) begin
      r_instr       <= w_rd_data;
      r_instr_valid <= 1'b1;
      r_instr_pc    <= r_pc;
      r_pc          <= r_pc + 32'd4;
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign pc          = r_pc;
  assign fault       = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural fetch model compared every cycle.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 64;
  localparam logic [31:0] HALT  = 32'hFC00_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] instr, instr_pc, pc;
  logic        instr_valid, halted, fault;

  instr_fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .pc             (pc),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: program semantics expressed directly as pc arithmetic over a word array.
  typedef enum int {M_IDLE, M_RUN, M_STOP} mstate_e;
  mstate_e     m_state = M_IDLE;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_ipc = 32'h0;
  logic        m_valid = 1'b0, m_halted = 1'b0, m_fault = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_state = M_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    end else if (m_state == M_IDLE) begin
      if (load_en) m_mem[load_addr] = load_data;
      if (start) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_instr = 32'h0; m_valid = 1'b0;
        if ((redirect_pc % 4) != 0 || (redirect_pc / 4) >= 32'(DEPTH)) begin
          m_state = M_STOP; m_halted = 1'b1; m_fault = 1'b1;
        end
      end else if (!stall) begin
        if ((m_pc / 4) >= 32'(DEPTH)) begin
          m_state = M_STOP; m_halted = 1'b1; m_fault = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
        end else if (m_mem[m_pc / 4] == HALT) begin
          m_state = M_STOP; m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
          m_instr = m_mem[m_pc / 4]; m_valid = 1'b1; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("cyc_instr",       instr,               m_instr);
      chk("cyc_instr_valid", 32'(instr_valid),    32'(m_valid));
      chk("cyc_instr_pc",    instr_pc,            m_ipc);
      chk("cyc_pc",          pc,                  m_pc);
      chk("cyc_halted",      32'(halted),         32'(m_halted));
      chk("cyc_fault",       32'(fault),          32'(m_fault));
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = 6'(a); load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int cyc;

    repeat (2) step();
    RST = 1'b0;
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);

    // Basic program ending on a halt word.
    load(0, 32'h0001_0820);
    load(1, 32'h0022_0820);
    load(2, HALT);
    start_run();
    chk("t1_no_valid_yet", 32'(instr_valid), 32'h0);
    step();
    chk("t1_instr0", instr, 32'h0001_0820);
    chk("t1_ipc0", instr_pc, 32'h0);
    chk("t1_valid0", 32'(instr_valid), 32'h1);
    step();
    chk("t1_instr1", instr, 32'h0022_0820);
    chk("t1_ipc1", instr_pc, 32'h4);
    step();
    chk("t1_valid_end", 32'(instr_valid), 32'h0);
    chk("t1_halted", 32'(halted), 32'h1);
    chk("t1_fault", 32'(fault), 32'h0);
    chk("t1_pc", pc, 32'h8);

    // Stall for three cycles after the first instruction.
    do_reset();
    start_run();
    step();
    chk("t2_first", instr, 32'h0001_0820);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_instr", instr, 32'h0001_0820);
      chk("t2_stall_pc", pc, 32'h4);
    end
    stall = 1'b0;
    step();
    chk("t2_second", instr, 32'h0022_0820);
    chk("t2_second_ipc", instr_pc, 32'h4);

    // Redirect while stalled squashes one slot.
    do_reset();
    load(4, 32'h0043_0820);
    load(5, HALT);
    start_run();
    step();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("t3_bubble_instr", instr, 32'h0);
    chk("t3_bubble_valid", 32'(instr_valid), 32'h0);
    chk("t3_pc", pc, 32'h10);
    step();
    chk("t3_target", instr, 32'h0043_0820);
    chk("t3_target_ipc", instr_pc, 32'h10);
    step();
    chk("t3_halted", 32'(halted), 32'h1);
    chk("t3_pc_halt", pc, 32'h14);

    // Misaligned and out-of-range redirect targets.
    do_reset();
    start_run();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    chk("t4_mis_halted", 32'(halted), 32'h1);
    chk("t4_mis_fault", 32'(fault), 32'h1);
    chk("t4_mis_pc", pc, 32'h6);
    do_reset();
    start_run();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("t4_oor_halted", 32'(halted), 32'h1);
    chk("t4_oor_fault", 32'(fault), 32'h1);
    chk("t4_oor_valid", 32'(instr_valid), 32'h0);

    // Run off the end of a fully populated memory.
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(i, 32'h2000_0000 + 32'(i));
    start_run();
    cnt = 0;
    cyc = 0;
    while (!halted && cyc < 200) begin
      step();
      if (instr_valid) cnt++;
      cyc++;
    end
    chk("t5_timeout", 32'(cyc < 200), 32'h1);
    chk("t5_count", 32'(cnt), 32'd64);
    chk("t5_halted", 32'(halted), 32'h1);
    chk("t5_fault", 32'(fault), 32'h1);
    chk("t5_pc", pc, 32'h100);

    // Asynchronous reset mid-run, then replay from preserved memory.
    do_reset();
    start_run();
    repeat (5) step();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_async_instr", instr, 32'h0);
    chk("t6_async_valid", 32'(instr_valid), 32'h0);
    chk("t6_async_ipc", instr_pc, 32'h0);
    chk("t6_async_pc", pc, 32'h0);
    chk("t6_async_halted", 32'(halted), 32'h0);
    chk("t6_async_fault", 32'(fault), 32'h0);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    load_en = 1'b1; load_addr = 6'd1; load_data = HALT; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    step();
    chk("t6_replay_instr", instr, 32'h2000_0000);
    chk("t6_replay_ipc", instr_pc, 32'h0);
    step();
    chk("t6_replay_halted", 32'(halted), 32'h1);
    chk("t6_replay_fault", 32'(fault), 32'h0);
    chk("t6_replay_pc", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side producer for execute_unit: holds a loadable instruction memory and a program counter.
- Streams one 32-bit MIPS word per cycle onto the `instr` bus that execute_unit consumes.
- Supports stall, branch/jump redirect with squash, a halt word, and fault detection.
- Replaces hand-driven `instr` stimulus so multi-instruction programs run end-to-end.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words; word index = pc[AW+1:2], AW = clog2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000, pc value after reset; must be word aligned.
- HALT_WORD, 32'hFC00_0000, opcode 6'b111111 word that stops fetch.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- load_en  in  1  write imem[load_addr] <= load_data; honoured only in IDLE.
- load_addr  in  AW  imem word index to write.
- load_data  in  32  instruction word to write.
- start  in  1  single-cycle pulse; IDLE -> RUN.
- stall  in  1  hold pc and all outputs.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  byte address of the redirect target.
- instr  out  32  fetched instruction to execute_unit; 0 (NOP) when not valid.
- instr_valid  out  1  instr holds a real, non-squashed instruction.
- instr_pc  out  32  byte address of instr.
- pc  out  32  next fetch address.
- halted  out  1  fetch has stopped; sticky until RST.
- fault  out  1  halted due to an out-of-range or misaligned pc; sticky.

Behaviour:
- Reset (async, any state, including mid-RUN):
  - state = IDLE; pc = RESET_PC.
  - instr = 0, instr_valid = 0, instr_pc = 0, halted = 0, fault = 0.
  - imem contents are not cleared.
- States and transitions: IDLE, RUN, HALTED.
  - IDLE: load_en writes imem. start -> RUN.
  - If load_en and start are asserted in the same cycle, the write takes effect and the first RUN fetch observes it.
  - RUN: load_en is ignored; start is ignored.
  - HALTED: only RST leaves this state. instr = 0, instr_valid = 0, pc is frozen.
- RUN cycle, priority redirect > stall > fetch:
  - redirect_valid:
    - pc <= redirect_pc.
    - instr <= 0, instr_valid <= 0 (one bubble, which squashes the word at the old pc).
    - Applies even if stall = 1.
    - If redirect_pc[1:0] != 0 or its word index >= IMEM_DEPTH: state <= HALTED, fault <= 1, pc <= redirect_pc.
  - stall (no redirect): pc, instr, instr_valid and instr_pc all hold.
  - fetch: let w = imem[pc index].
    - If the pc index >= IMEM_DEPTH: HALTED, fault = 1, instr_valid <= 0.
    - Else if w == HALT_WORD: HALTED, fault = 0, instr_valid <= 0; the halt word is never emitted.
    - Else: instr <= w, instr_valid <= 1, instr_pc <= pc, pc <= pc + 4.
- Latency: a word addressed by pc in cycle N appears on instr after edge N+1, i.e. a registered one-cycle fetch.
- First valid instruction is one cycle after start.
- Wrap-around: pc + 4 is 32-bit modulo. Any pc beyond the imem range faults; it never silently wraps into the memory.
- Redirect in the same cycle as a HALT_WORD or out-of-range fetch: redirect wins, no halt.
- Redirect while IDLE or HALTED: ignored.
- Stall with start in IDLE: the transition still occurs; stall only affects RUN.

Decomposition:
- Shared package mips_pkg:
  - localparam HALT_WORD and NOP_WORD (32'h0).
  - Fetch state enum {IDLE, RUN, HALTED}.
  - Opcode field slice constants.
- One natural sub-module: instr_mem, a synchronous-write, combinational-read IMEM_DEPTH x 32 array.
- The pc, FSM and output registers stay in instr_fetch_unit.

Test Plan:
- Reset values: load imem[0..2] = 32'h00010820, 32'h00220820, HALT_WORD; start.
  - Required: instr = 32'h00010820 @ instr_pc 0, then 32'h00220820 @ instr_pc 4.
  - Then instr_valid = 0, halted = 1, fault = 0, pc = 8.
- Stall for 3 cycles after the first valid instruction: instr stays 32'h00010820 and pc stays 4 for all 3 cycles; the second instruction appears on the cycle after stall drops.
- Redirect to 32'h10 while stalled, with imem[4] = 32'h00430820:
  - Required: one cycle instr = 0, instr_valid = 0.
  - Then instr = 32'h00430820, instr_pc = 32'h10.
- Redirect to 32'h6 → halted = 1, fault = 1, pc = 32'h6. Redirect to 32'h100 (index 64, depth 64) → halted = 1, fault = 1.
- Fetch run-off past the end: fill imem with non-halt words and run → 64 valid instructions, then halted = 1, fault = 1.
- RST mid-RUN at an arbitrary time:
  - Required: all outputs return to reset values asynchronously, before the next edge.
  - load_en after reset is accepted again; imem contents are preserved, so start replays from RESET_PC.
